// File: rtl/sound_scheduler.sv
// Buzzer arbiter and note sequencer: latches effect requests, serves them by fixed priority,
// and plays each effect from a constant ROM. Optional preemption via `SOUND_PREEMPT_EN.
module sound_scheduler #(
   parameter int unsigned TICK_CYCLES = 5_000_000,
   parameter int unsigned GAP_CYCLES  = 500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       mute,
   output logic [5:0] note,
   output logic       busy,
   output logic [1:0] active_id,
   output logic       done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] PLAY  = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   // Each step is {note[5:0], len[3:0]}; len = 0 marks the end of the effect.
   function automatic logic [9:0] rom_step(input logic [1:0] id, input logic [2:0] idx);
      logic [9:0] s;
      s = 10'd0;
      case (id)
         2'd0: case (idx)
            3'd0: s = {6'd32, 4'd2};
            3'd1: s = {6'd27, 4'd2};
            3'd2: s = {6'd24, 4'd2};
            3'd3: s = {6'd20, 4'd2};
            3'd4: s = {6'd12, 4'd6};
            default: s = 10'd0;
         endcase
         2'd1: case (idx)
            3'd0: s = {6'd30, 4'd2};
            3'd1: s = {6'd34, 4'd2};
            default: s = 10'd0;
         endcase
         2'd2: case (idx)
            3'd0: s = {6'd12, 4'd4};
            default: s = 10'd0;
         endcase
         default: case (idx)
            3'd0: s = {6'd20, 4'd1};
            3'd1: s = {6'd24, 4'd1};
            3'd2: s = {6'd27, 4'd1};
            3'd3: s = {6'd32, 4'd3};
            default: s = 10'd0;
         endcase
      endcase
      return s;
   endfunction

   function automatic logic [1:0] lowest(input logic [3:0] p);
      if (p[0])      return 2'd0;
      else if (p[1]) return 2'd1;
      else if (p[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] id);
      return 4'b0001 << id;
   endfunction

`ifdef SOUND_PREEMPT_EN
   function automatic logic [3:0] higher_than(input logic [1:0] id);
      case (id)
         2'd0:    return 4'b0000;
         2'd1:    return 4'b0001;
         2'd2:    return 4'b0011;
         default: return 4'b0111;
      endcase
   endfunction
`endif

   logic [1:0]  state, state_d;
   logic [3:0]  pending, pending_d, clr;
   logic [2:0]  step, step_d;
   logic [5:0]  cur_note, cur_note_d, note_src;
   logic [3:0]  len_q, len_d;
   logic [31:0] cnt, cnt_d, play_cycles;
   logic [1:0]  id_d;
   logic        done_d;
   logic [9:0]  rom;

   assign rom         = rom_step(active_id, step);
   assign play_cycles = {28'd0, len_q} * TICK_CYCLES;

   always_comb begin
      state_d    = state;
      step_d     = step;
      cnt_d      = cnt;
      cur_note_d = cur_note;
      len_d      = len_q;
      id_d       = active_id;
      done_d     = 1'b0;
      clr        = 4'b0000;
      note_src   = 6'd0;
      case (state)
         IDLE: begin
            if (pending != 4'b0000) begin
               id_d    = lowest(pending);
               clr     = onehot(lowest(pending));
               step_d  = 3'd0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (rom[3:0] == 4'd0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cur_note_d = rom[9:4];
               len_d      = rom[3:0];
               cnt_d      = 32'd0;
               note_src   = rom[9:4];
               state_d    = PLAY;
            end
         end
         PLAY: begin
            if (cnt == play_cycles - 32'd1) begin
               cnt_d = 32'd0;
               if (GAP_CYCLES != 0) begin
                  state_d = GAP;
               end else if (step == 3'd7) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  step_d  = step + 3'd1;
                  state_d = FETCH;
               end
            end else begin
               cnt_d    = cnt + 32'd1;
               note_src = cur_note;
            end
         end
         default: begin
            if (cnt == GAP_CYCLES - 32'd1) begin
               cnt_d = 32'd0;
               // Stepping past the last ROM slot ends the effect instead of wrapping.
               if (step == 3'd7) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  step_d  = step + 3'd1;
                  state_d = FETCH;
               end
            end else begin
               cnt_d = cnt + 32'd1;
            end
         end
      endcase
`ifdef SOUND_PREEMPT_EN
      if (state != IDLE && (pending & higher_than(active_id)) != 4'b0000) begin
         id_d     = lowest(pending);
         clr      = onehot(lowest(pending));
         step_d   = 3'd0;
         cnt_d    = 32'd0;
         done_d   = 1'b0;
         note_src = 6'd0;
         state_d  = FETCH;
      end
`endif
   end

   // A request arriving on the launch edge re-sets its own bit.
   assign pending_d = (pending & ~clr) | req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pending   <= 4'b0000;
         step      <= 3'd0;
         cnt       <= 32'd0;
         cur_note  <= 6'd0;
         len_q     <= 4'd0;
         active_id <= 2'd0;
         note      <= 6'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         pending   <= pending_d;
         step      <= step_d;
         cnt       <= cnt_d;
         cur_note  <= cur_note_d;
         len_q     <= len_d;
         active_id <= id_d;
         note      <= mute ? 6'd0 : note_src;
         busy      <= (state_d != IDLE);
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: a timeline model expands each launched effect into per-cycle
// expected outputs, checked every cycle, plus literal checks for the directed scenarios.
module tb_sound_scheduler;

   localparam int T = 4;
   localparam int G = 1;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic       mute;
   logic [5:0] note;
   logic       busy;
   logic [1:0] active_id;
   logic       done;

   sound_scheduler #(.TICK_CYCLES(T), .GAP_CYCLES(G)) dut (
      .clk(clk), .reset(reset), .req(req), .mute(mute),
      .note(note), .busy(busy), .active_id(active_id), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Melodies written as note/length lists per effect.
   int mel_n [4][5] = '{'{32, 27, 24, 20, 12}, '{30, 34, 0, 0, 0}, '{12, 0, 0, 0, 0}, '{20, 24, 27, 32, 0}};
   int mel_l [4][5] = '{'{2, 2, 2, 2, 6}, '{2, 2, 0, 0, 0}, '{4, 0, 0, 0, 0}, '{1, 1, 1, 3, 0}};
   int mel_c [4]    = '{5, 2, 1, 4};

   typedef struct packed {
      logic [5:0] n;
      logic       b;
      logic       d;
   } ent_t;

   ent_t       tl[$];
   logic [3:0] m_pend = 4'b0;
   logic       m_busy = 1'b0;
   logic [1:0] m_id = 2'd0;
   logic [5:0] e_note = 6'd0;
   logic       e_busy = 1'b0, e_done = 1'b0;
   logic [1:0] e_id = 2'd0;
   bit         have = 1'b0;

   function automatic ent_t mk(input int n, input bit b, input bit d);
      ent_t e;
      e.n = 6'(n);
      e.b = b;
      e.d = d;
      return e;
   endfunction

   function automatic int first_set(input logic [3:0] p);
      for (int i = 0; i < 4; i++) if (p[i]) return i;
      return 4;
   endfunction

   task automatic build(input int id);
      tl.delete();
      tl.push_back(mk(0, 1, 0));
      for (int i = 0; i < mel_c[id]; i++) begin
         for (int c = 0; c < mel_l[id][i] * T; c++) tl.push_back(mk(mel_n[id][i], 1, 0));
         for (int c = 0; c < G; c++) tl.push_back(mk(0, 1, 0));
         tl.push_back(mk(0, 1, 0));
      end
      tl.push_back(mk(0, 0, 1));
   endtask

   task automatic model_step();
      ent_t e;
      int   lo;
      bit   launch;
      if (reset) begin
         tl.delete();
         m_pend = 4'b0;
         m_busy = 1'b0;
         m_id   = 2'd0;
         e      = mk(0, 0, 0);
      end else begin
         lo     = first_set(m_pend);
         launch = 1'b0;
`ifdef SOUND_PREEMPT_EN
         if (m_busy && lo < int'(m_id)) launch = 1'b1;
`endif
         if (!m_busy && tl.size() == 0 && lo < 4) launch = 1'b1;
         if (launch) begin
            m_pend[lo] = 1'b0;
            m_id       = 2'(lo);
            build(lo);
         end
         if (tl.size() > 0) e = tl.pop_front();
         else e = mk(0, 0, 0);
         m_busy = e.b;
         m_pend = m_pend | req;
      end
      e_note = mute ? 6'd0 : e.n;
      e_busy = e.b;
      e_done = e.d;
      e_id   = m_id;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (have) begin
            chk("model_note", 32'(note), 32'(e_note));
            chk("model_busy", 32'(busy), 32'(e_busy));
            chk("model_done", 32'(done), 32'(e_done));
            chk("model_id", 32'(active_id), 32'(e_id));
         end
         model_step();
         have = 1'b1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [3:0] v);
      req = v;
      cyc(1);
      req = 4'b0;
   endtask

   int dcount, bcount;

   task automatic run_count(input int n);
      repeat (n) begin
         cyc(1);
         if (done) dcount++;
         if (busy) bcount++;
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b0;
      mute  = 1'b0;
      cyc(3);
      chk("reset_note", 32'(note), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_id", 32'(active_id), 0);
      chk("reset_done", 32'(done), 0);
      reset = 1'b0;
      cyc(2);

      // Single hit
      pulse(4'b0010);
      cyc(2);  chk("hit_first_note", 32'(note), 30);
      cyc(7);  chk("hit_first_last", 32'(note), 30);
      cyc(1);  chk("hit_gap", 32'(note), 0);
      cyc(2);  chk("hit_second_note", 32'(note), 34);
      cyc(9);  chk("hit_pre_done", 32'(done), 0);
      chk("hit_pre_busy", 32'(busy), 1);
      cyc(1);  chk("hit_done", 32'(done), 1);
      chk("hit_busy_low", 32'(busy), 0);
      cyc(1);  chk("hit_done_one_cycle", 32'(done), 0);
      cyc(5);

      // Simultaneous miss + start
      pulse(4'b1100);
      cyc(20); chk("simul_miss_done", 32'(done), 1);
      chk("simul_miss_id", 32'(active_id), 2);
      cyc(1);  chk("simul_start_id", 32'(active_id), 3);
      chk("simul_start_busy", 32'(busy), 1);
      cyc(40);

      // Duplicate hit requests
      dcount = 0; bcount = 0;
      pulse(4'b0010);
      run_count(5);
      pulse(4'b0010);
      run_count(3);
      pulse(4'b0010);
      run_count(70);
      chk("dup_done_count", 32'(dcount), 2);

      // Muted hit
      mute = 1'b1;
      pulse(4'b0010);
      cyc(2);  chk("mute_note", 32'(note), 0);
      cyc(19); chk("mute_pre_done", 32'(done), 0);
      cyc(1);  chk("mute_done", 32'(done), 1);
      cyc(3);
      mute = 1'b0;
      cyc(3);

      // Reset in the middle of PLAY with another request pending
      pulse(4'b0010);
      cyc(2);
      pulse(4'b1000);
      cyc(1);
      reset = 1'b1;
      cyc(1);
      chk("rst_note", 32'(note), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_id", 32'(active_id), 0);
      reset = 1'b0;
      dcount = 0; bcount = 0;
      run_count(40);
      chk("rst_no_done", 32'(dcount), 0);
      chk("rst_pending_cleared", 32'(bcount), 0);

      // Game-over request during miss PLAY
      dcount = 0;
      pulse(4'b0100);
      cyc(4);
      pulse(4'b0001);
      cyc(2);
`ifdef SOUND_PREEMPT_EN
      chk("preempt_note", 32'(note), 32);
      chk("preempt_id", 32'(active_id), 0);
      run_count(110);
      chk("preempt_done_count", 32'(dcount), 1);
`else
      chk("nopreempt_note", 32'(note), 12);
      chk("nopreempt_id", 32'(active_id), 2);
      run_count(110);
      chk("nopreempt_done_count", 32'(dcount), 2);
`endif
      cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
